// File: rtl/lu_seq_pkg.sv
// Shared definitions for the sequential logic unit and its slice datapath:
// operation encodings and FSM state encoding.
package lu_seq_pkg;

    localparam logic [2:0] LU_AND   = 3'b000;
    localparam logic [2:0] LU_OR    = 3'b001;
    localparam logic [2:0] LU_XOR   = 3'b010;
    localparam logic [2:0] LU_NAND  = 3'b011;
    localparam logic [2:0] LU_NOR   = 3'b100;
    localparam logic [2:0] LU_XNOR  = 3'b101;
    localparam logic [2:0] LU_NOTA  = 3'b110;
    localparam logic [2:0] LU_PASSA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } lu_state_e;

endpackage

// File: rtl/lu_slice.sv
// Combinational SLICE-bit logic unit: applies one of the eight bitwise
// operations to a and b. Shared between the sequential LU and the ALU.
module lu_slice
    import lu_seq_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    // Operation table; every encoding is covered, PASS A doubles as the default.
    always_comb begin
        y = a;
        case (op)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_XOR:  y = a ^ b;
            LU_NAND: y = ~(a & b);
            LU_NOR:  y = ~(a | b);
            LU_XNOR: y = ~(a ^ b);
            LU_NOTA: y = ~a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/lu_seq.sv
// Sequential logic unit: processes WIDTH-bit operands SLICE bits per cycle,
// LSB slice first, behind a start/busy/done handshake. Y and zero are only
// updated on the completion edge so partial results are never visible.
module lu_seq
    import lu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       LUOP,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets where the operand does not split into whole slices.
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
        $error("lu_seq: WIDTH (%0d) must be a positive multiple of SLICE (%0d)", WIDTH, SLICE);
    end

    lu_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] slice_y;
    logic [WIDTH-1:0] res_next;

    lu_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_q[SLICE-1:0]),
        .b  (b_q[SLICE-1:0]),
        .op (op_q),
        .y  (slice_y)
    );

    // New slice enters at the MSB end so the word is LSB-aligned after N shifts.
    if (SLICE == WIDTH) begin : g_res_full
        assign res_next = slice_y;
    end else begin : g_res_shift
        assign res_next = {slice_y, res_q[WIDTH-1:SLICE]};
    end

    // Next-state logic: capture on accepted start, shift through RUN, publish on the last slice.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        y_d     = y_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = LUOP;
                    cnt_d   = CW'(N - 1);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d = res_next;
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                if (cnt_q == '0) begin
                    y_d     = res_next;
                    zero_d  = (res_next == '0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Y    = y_q;
    assign zero = zero_q;

endmodule
